// File: rtl/quad_gen_pkg.sv
// Shared definitions for the quadrature generator: FSM states, Gray table, direction codes.
package quad_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // {a,b} per phase, entry p at bits [2p+1:2p]: 0=00, 1=10, 2=11, 3=01
  localparam logic [7:0] GRAY_TABLE = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [1:0] gray_code(input logic [1:0] phase);
    return GRAY_TABLE[{phase, 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
    return (dir == DIR_UP) ? phase + 2'd1 : phase - 2'd1;
  endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Step-command handshake between a command source (master) and the generator (slave).
interface quad_encoder_gen_if #(
  parameter int STEP_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic [STEP_WIDTH-1:0] cmd_steps;
  logic [DIV_WIDTH-1:0]  cmd_half_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_half_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_half_period,
    output cmd_ready
  );
endinterface

// File: rtl/quad_gen_timer.sv
// Reloadable down-counter; tick_o is high while the count sits at zero.
module quad_gen_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] load_value_i,
  output logic [DIV_WIDTH-1:0] value_o,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] value_q;

  // Saturates at zero so an idle timer never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_value_i;
    end else if (value_q != '0) begin
      value_q <= value_q - DIV_WIDTH'(1);
    end
  end

  assign value_o = value_q;
  assign tick_o  = (value_q == '0);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B generator driven by step commands.
// Optional contact chatter on each transition when QUAD_GEN_BOUNCE_EN is defined.
module quad_encoder_gen
  import quad_gen_pkg::*;
#(
  parameter int STEP_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int BOUNCE_LEN = 2
) (
  input  logic               clk,
  input  logic               reset,
  quad_encoder_gen_if.slave  cmd,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done
);

  state_t                state_q;
  logic [1:0]            phase_q;
  logic                  dir_q;
  logic [STEP_WIDTH-1:0] steps_left_q;
  logic [DIV_WIDTH-1:0]  hp_m1_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  a_q;
  logic                  b_q;

  logic                  accept;
  logic                  do_step;
  logic [1:0]            phase_d;
  logic [1:0]            ab_cur;
  logic [1:0]            ab_next;
  logic [DIV_WIDTH-1:0]  hp_eff;
  logic [DIV_WIDTH-1:0]  accept_reload;
  logic                  timer_load;
  logic [DIV_WIDTH-1:0]  timer_load_value;
  logic [DIV_WIDTH-1:0]  timer_value;
  logic                  timer_tick;

  always_comb begin
    accept           = cmd.cmd_valid & ready_q;
    hp_eff           = (cmd.cmd_half_period == '0) ? DIV_WIDTH'(1) : cmd.cmd_half_period;
    accept_reload    = hp_eff - DIV_WIDTH'(1);
    do_step          = ((state_q == ST_WAIT) || (state_q == ST_STEP)) &&
                       timer_tick && (steps_left_q != '0);
    phase_d          = next_phase(phase_q, dir_q);
    ab_cur           = gray_code(phase_q);
    ab_next          = gray_code(phase_d);
    timer_load       = accept | do_step;
    timer_load_value = accept ? accept_reload : hp_m1_q;
  end

  quad_gen_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (timer_load),
    .load_value_i (timer_load_value),
    .value_o      (timer_value),
    .tick_o       (timer_tick)
  );

  // STEP marks the cycle after a transition; reaching it with no steps left
  // (including a zero-step command) leads to DONE one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= 2'd0;
      dir_q        <= DIR_DOWN;
      steps_left_q <= '0;
      hp_m1_q      <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            dir_q        <= cmd.cmd_dir;
            steps_left_q <= cmd.cmd_steps;
            hp_m1_q      <= accept_reload;
            ready_q      <= 1'b0;
            state_q      <= (cmd.cmd_steps == '0) ? ST_STEP : ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT, ST_STEP: begin
          if (do_step) begin
            phase_q      <= phase_d;
            steps_left_q <= steps_left_q - STEP_WIDTH'(1);
            state_q      <= ST_STEP;
          end else if ((state_q == ST_STEP) && (steps_left_q == '0)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef QUAD_GEN_BOUNCE_EN
  localparam int CHAT_W = $clog2(2 * BOUNCE_LEN + 2);

  logic [CHAT_W-1:0] chat_cnt_q;
  logic              chat_on_a_q;

  // A new transition rewrites both lines from the table, cutting any chatter short.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      chat_cnt_q  <= '0;
      chat_on_a_q <= 1'b0;
    end else if (do_step) begin
      {a_q, b_q}  <= ab_next;
      chat_cnt_q  <= CHAT_W'(2 * BOUNCE_LEN);
      chat_on_a_q <= ab_next[1] ^ ab_cur[1];
    end else if (chat_cnt_q != '0) begin
      if (chat_on_a_q) begin
        a_q <= ~a_q;
      end else begin
        b_q <= ~b_q;
      end
      chat_cnt_q <= chat_cnt_q - CHAT_W'(1);
    end
  end
`else
  logic unused_ab_cur;
  assign unused_ab_cur = ^ab_cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else if (do_step) begin
      {a_q, b_q} <= ab_next;
    end
  end
`endif

  logic unused_timer_value;
  assign unused_timer_value = ^timer_value;

  assign cmd.cmd_ready = ready_q;
  assign busy          = ~ready_q;
  assign done          = done_q;
  assign a             = a_q;
  assign b             = b_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Randomized self-checking bench for quad_encoder_gen against a timing-formula model.
module tb_quad_encoder_gen;

  localparam int SW = 8;
  localparam int DW = 16;
  localparam int BL = 2;
`ifdef QUAD_GEN_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic clk;
  logic reset;
  logic a, b, busy, done;
  int   pass_cnt;
  int   total_cnt;
  int   cyc;

  // model state: current phase, cycle and line mask of the latest transition
  int         m_phase;
  int         m_last_cyc;
  logic [1:0] m_mask;

  quad_encoder_gen_if #(.STEP_WIDTH(SW), .DIV_WIDTH(DW)) cmd_if ();

  quad_encoder_gen #(
    .STEP_WIDTH (SW),
    .DIV_WIDTH  (DW),
    .BOUNCE_LEN (BL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_if),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] gray_of(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] exp_ab();
    logic [1:0] g;
    int d;
    g = gray_of(m_phase);
    d = cyc - m_last_cyc;
    if (BOUNCE && d >= 1 && d <= 2 * BL && (d % 2) == 1) g = g ^ m_mask;
    return g;
  endfunction

  task automatic model_reset();
    m_phase    = 0;
    m_last_cyc = -1000;
    m_mask     = 2'b00;
  endtask

  // Drives one command and checks every cycle up to its done cycle (or abort_at).
  task automatic issue(input bit dir, input int steps, input int hp, input bit hold,
                       input int abort_at, input string tag);
    int H, N, last, k;
    logic [1:0] old;
    logic [4:0] obs, expv;
    bit rdy;
    H = (hp == 0) ? 1 : hp;
    N = steps;
    total_cnt++;
    if (cmd_if.cmd_ready !== 1'b1)
      $display("FAIL %s pre_ready: cmd_ready=%b required 1", tag, cmd_if.cmd_ready);
    else
      pass_cnt++;
    cmd_if.cmd_valid       = 1'b1;
    cmd_if.cmd_dir         = dir;
    cmd_if.cmd_steps       = SW'(steps);
    cmd_if.cmd_half_period = DW'(hp);
    @(posedge clk); #1;
    if (hold) begin
      cmd_if.cmd_dir         = 1'($urandom);
      cmd_if.cmd_steps       = SW'($urandom);
      cmd_if.cmd_half_period = DW'($urandom);
    end else begin
      cmd_if.cmd_valid = 1'b0;
    end
    last = (abort_at > 0) ? abort_at : N * H + 1;
    for (int t = 1; t <= last; t++) begin
      @(posedge clk); #1;
      k = t / H;
      if ((t % H) == 0 && k >= 1 && k <= N) begin
        old        = gray_of(m_phase);
        m_phase    = (m_phase + (dir ? 1 : 3)) % 4;
        m_mask     = old ^ gray_of(m_phase);
        m_last_cyc = cyc;
      end
      rdy  = (t == N * H + 1);
      expv = {exp_ab(), rdy, rdy, ~rdy};
      obs  = {a, b, done, cmd_if.cmd_ready, busy};
      total_cnt++;
      if (obs !== expv)
        $display("FAIL %s t=%0d {a,b,done,ready,busy}=%b required %b", tag, t, obs, expv);
      else
        pass_cnt++;
    end
  endtask

  task automatic idle(input int n, input string tag);
    logic [4:0] obs, expv;
    cmd_if.cmd_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      expv = {exp_ab(), 1'b0, 1'b1, 1'b0};
      obs  = {a, b, done, cmd_if.cmd_ready, busy};
      total_cnt++;
      if (obs !== expv)
        $display("FAIL %s idle {a,b,done,ready,busy}=%b required %b", tag, obs, expv);
      else
        pass_cnt++;
    end
  endtask

  task automatic do_reset(input int n, input string tag);
    logic [4:0] obs;
    reset            = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      obs = {a, b, done, cmd_if.cmd_ready, busy};
      total_cnt++;
      if (obs !== 5'b00010)
        $display("FAIL %s reset {a,b,done,ready,busy}=%b required 00010", tag, obs);
      else
        pass_cnt++;
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(3, "reset_init");
    idle(2, "reset_init");
    issue(1'b1, 1, 1, 1'b0, 0, "reset_move");
    idle(2, "reset_move");
    do_reset(1, "reset_idle");
    idle(2, "reset_idle");
    $display("test_reset done");
  endtask

  task automatic test_up();
    issue(1'b1, 4, 3, 1'b0, 0, "up4_h3");
    idle(1, "up4_h3");
    $display("test_up done phase=%0d", m_phase);
  endtask

  task automatic test_persist();
    issue(1'b0, 2, 1, 1'b0, 0, "down2_h1");
    idle(1, "down2_h1");
    issue(1'b1, 2, 1, 1'b0, 0, "up2_h1");
    idle(1, "up2_h1");
    $display("test_persist done phase=%0d", m_phase);
  endtask

  task automatic test_zero();
    issue(1'b1, 0, 4, 1'b0, 0, "steps0");
    idle(1, "steps0");
    issue(1'b0, 1, 0, 1'b0, 0, "hp0");
    idle(1, "hp0");
    $display("test_zero done phase=%0d", m_phase);
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 3, 2, 1'b1, 0, "b2b_first");
    issue(1'b0, 2, 3, 1'b1, 0, "b2b_second");
    issue(1'b1, 1, 1, 1'b0, 0, "b2b_third");
    idle(1, "b2b");
    $display("test_back_to_back done phase=%0d", m_phase);
  endtask

  task automatic test_random();
    bit d, h;
    int s, p;
    for (int i = 0; i < 12; i++) begin
      d = 1'($urandom);
      s = $urandom_range(0, 6);
      p = $urandom_range(0, 4);
      h = 1'($urandom);
      issue(d, s, p, h, 0, "random");
      if (!h) idle($urandom_range(1, 3), "random");
      $display("test_random cmd %0d dir=%0d steps=%0d hp=%0d hold=%0d", i, d, s, p, h);
    end
    idle(1, "random_end");
  endtask

  task automatic test_abort();
    logic [4:0] obs;
    do_reset(1, "abort_pre");
    issue(1'b1, 5, 2, 1'b0, 4, "abort_run");
    reset = 1'b1;
    @(posedge clk); #1;
    obs = {a, b, done, cmd_if.cmd_ready, busy};
    total_cnt++;
    if (obs !== 5'b00010)
      $display("FAIL abort_reset {a,b,done,ready,busy}=%b required 00010", obs);
    else
      pass_cnt++;
    reset = 1'b0;
    model_reset();
    idle(15, "abort_after");
    $display("test_abort done");
  endtask

`ifdef QUAD_GEN_BOUNCE_EN
  task automatic test_bounce();
    logic expa;
    do_reset(1, "bounce_pre");
    cmd_if.cmd_valid       = 1'b1;
    cmd_if.cmd_dir         = 1'b1;
    cmd_if.cmd_steps       = SW'(1);
    cmd_if.cmd_half_period = DW'(10);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      @(posedge clk); #1;
      expa = (t < 10) ? 1'b0 : ((t == 11 || t == 13) ? 1'b0 : 1'b1);
      total_cnt++;
      if ({a, b} !== {expa, 1'b0})
        $display("FAIL bounce t=%0d ab=%b required %b", t, {a, b}, {expa, 1'b0});
      else
        pass_cnt++;
    end
    do_reset(1, "bounce_post");
    $display("test_bounce done");
  endtask
`endif

  initial begin
    pass_cnt               = 0;
    total_cnt              = 0;
    reset                  = 1'b1;
    cmd_if.cmd_valid       = 1'b0;
    cmd_if.cmd_dir         = 1'b0;
    cmd_if.cmd_steps       = '0;
    cmd_if.cmd_half_period = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_up();
    test_persist();
    test_zero();
    test_back_to_back();
    test_random();
    test_abort();
`ifdef QUAD_GEN_BOUNCE_EN
    test_bounce();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
